// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch and data requests onto one multicycle memory port
module mem_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  if_done,
  output logic                  d_done,
  output logic                  ir_load,
  output logic                  mdr_load,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic gnt_d, we_r, grant, last;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    grant   = (state == IDLE) && (if_req || d_req);
    last    = (state == ACCESS) && (cnt == 4'd0);
    state_n = (state == IDLE)   ? (grant ? ACCESS : IDLE) :
              (state == ACCESS) ? (last ? DONE : ACCESS) : IDLE;
  end
  // data wins the grant; the registered copy keeps the port stable while requesters move on
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      gnt_d     <= 1'b0;
      we_r      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '1;
    end else begin
      if (grant) begin
        cnt       <= 4'(MEM_LATENCY - 1);
        gnt_d     <= d_req;
        we_r      <= d_req && d_we;
        mem_addr  <= d_req ? d_addr : if_addr;
        mem_wdata <= d_req ? d_wdata : '0;
      end else if (state == ACCESS && !last)
        cnt <= cnt - 4'd1;
      if (last && !we_r)
        rdata <= mem_rdata;
    end
  end
  assign mem_en   = state == ACCESS;
  assign mem_we   = mem_en && we_r;
  assign busy     = state != IDLE;
  assign if_done  = state == DONE && !gnt_d;
  assign d_done   = state == DONE && gnt_d;
  assign ir_load  = if_done && !we_r;
  assign mdr_load = d_done && !we_r;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of the shared memory port sequencer
module tb_mem_access_ctrl;
  localparam int LAT = 2;
  logic clk = 0, rst = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, rd_val = 0;
  logic mem_en, mem_we, if_done, d_done, ir_load, mdr_load, busy;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [1:0] x_en, x_we, x_ifd, x_dd, x_ir, x_mdr, x_busy;
  logic [31:0] x_addr [2];
  logic [31:0] x_wd [2];
  logic [31:0] x_rd [2];
  int total = 0, bad = 0;
  logic [31:0] exp_rdata;
  int lat_if, lat_d, en_cnt, we_cnt, n_ifd, n_dd, n_ir, n_mdr;
  logic [31:0] first_addr, first_wdata;
  bit stable;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rd_val), .rdata(rdata), .if_done(if_done), .d_done(d_done),
    .ir_load(ir_load), .mdr_load(mdr_load), .busy(busy));
  mem_access_ctrl #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_en(x_en[0]), .mem_we(x_we[0]), .mem_addr(x_addr[0]),
    .mem_wdata(x_wd[0]), .mem_rdata(rd_val), .rdata(x_rd[0]), .if_done(x_ifd[0]), .d_done(x_dd[0]),
    .ir_load(x_ir[0]), .mdr_load(x_mdr[0]), .busy(x_busy[0]));
  mem_access_ctrl #(.MEM_LATENCY(15)) dut15 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_en(x_en[1]), .mem_we(x_we[1]), .mem_addr(x_addr[1]),
    .mem_wdata(x_wd[1]), .mem_rdata(rd_val), .rdata(x_rd[1]), .if_done(x_ifd[1]), .d_done(x_dd[1]),
    .ir_load(x_ir[1]), .mdr_load(x_mdr[1]), .busy(x_busy[1]));

  // Drives one request set and records what the port did; edge 0 is the grant edge.
  task automatic do_access(input bit fi, input bit di, input bit we, input bit early,
                           input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd,
                           input logic [31:0] rv);
    bit was_en = 0, seen = 0;
    logic [31:0] cur_a = 0, cur_w = 0;
    lat_if = -1; lat_d = -1; en_cnt = 0; we_cnt = 0;
    n_ifd = 0; n_dd = 0; n_ir = 0; n_mdr = 0; stable = 1;
    first_addr = 'x; first_wdata = 'x;
    if_req = fi; d_req = di; d_we = we; if_addr = fa; d_addr = da; d_wdata = wd; rd_val = rv;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        en_cnt++;
        we_cnt += int'(mem_we);
        if (!was_en) begin
          if (!seen) begin first_addr = mem_addr; first_wdata = mem_wdata; seen = 1; end
          cur_a = mem_addr; cur_w = mem_wdata;
        end else if (mem_addr !== cur_a || mem_wdata !== cur_w) stable = 0;
      end
      was_en = mem_en;
      if (early && i == 0) begin if_req = 0; d_req = 0; end
      if (if_done) begin n_ifd++; if (lat_if < 0) lat_if = i; if_req = 0; end
      if (d_done) begin n_dd++; if (lat_d < 0) lat_d = i; d_req = 0; end
      n_ir += int'(ir_load);
      n_mdr += int'(mdr_load);
      if ((!fi || lat_if >= 0) && (!di || lat_d >= 0)) break;
    end
    if_req = 0; d_req = 0;
    @(posedge clk); #1;
    n_ifd += int'(if_done); n_dd += int'(d_done); n_ir += int'(ir_load); n_mdr += int'(mdr_load);
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_en, mem_we, if_done, d_done, ir_load, mdr_load, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0", {mem_en, mem_we, if_done, d_done, ir_load, mdr_load, busy});
    end
    total++;
    if (rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_rdata got=%h exp=ffffffff", rdata); end
    total++;
    if (mem_addr !== 0 || mem_wdata !== 0) begin
      bad++; $display("FAIL reset_addr got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    rst = 0;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h80; rd_val = 32'h12345678;
    @(posedge clk); #1;
    total++;
    if (busy !== 1 || mem_en !== 1) begin bad++; $display("FAIL midreset_access got=%b%b exp=11", busy, mem_en); end
    rst = 1; if_req = 0;
    @(posedge clk); #1;
    total++;
    if (busy !== 0 || mem_en !== 0) begin bad++; $display("FAIL midreset_idle got=%b%b exp=00", busy, mem_en); end
    rst = 0;
    repeat (20) begin
      @(posedge clk); #1;
      n += int'(if_done) + int'(d_done) + int'(ir_load) + int'(mdr_load) + int'(busy);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL midreset_nodone got=%0d exp=0", n); end
    total++;
    if (rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL midreset_rdata got=%h exp=ffffffff", rdata); end
    exp_rdata = '1;
  endtask

  task automatic test_fetch();
    do_access(1, 0, 0, 0, 32'h40, 0, 0, 32'h8C220004);
    exp_rdata = 32'h8C220004;
    total++;
    if (lat_if !== LAT) begin bad++; $display("FAIL fetch_lat got=%0d exp=%0d", lat_if, LAT); end
    total++;
    if (en_cnt !== LAT || we_cnt !== 0) begin bad++; $display("FAIL fetch_en got=%0d/%0d exp=%0d/0", en_cnt, we_cnt, LAT); end
    total++;
    if (first_addr !== 32'h40 || !stable) begin bad++; $display("FAIL fetch_addr got=%h st=%0d exp=40", first_addr, stable); end
    total++;
    if (n_ifd !== 1 || n_ir !== 1 || n_dd !== 0 || n_mdr !== 0) begin
      bad++; $display("FAIL fetch_strobes got=%0d%0d%0d%0d exp=1100", n_ifd, n_ir, n_dd, n_mdr);
    end
    total++;
    if (rdata !== exp_rdata) begin bad++; $display("FAIL fetch_rdata got=%h exp=%h", rdata, exp_rdata); end
  endtask

  task automatic test_load();
    logic [31:0] v = $urandom;
    do_access(0, 1, 0, 0, 0, 32'h100, 0, v);
    exp_rdata = v;
    total++;
    if (lat_d !== LAT) begin bad++; $display("FAIL load_lat got=%0d exp=%0d", lat_d, LAT); end
    total++;
    if (n_dd !== 1 || n_mdr !== 1 || n_ifd !== 0 || n_ir !== 0) begin
      bad++; $display("FAIL load_strobes got=%0d%0d%0d%0d exp=1100", n_dd, n_mdr, n_ifd, n_ir);
    end
    total++;
    if (first_addr !== 32'h100 || rdata !== exp_rdata) begin
      bad++; $display("FAIL load_data got=%h/%h exp=100/%h", first_addr, rdata, exp_rdata);
    end
  endtask

  task automatic test_store();
    do_access(0, 1, 1, 0, 0, 32'h104, 32'hDEADBEEF, 32'h55555555);
    total++;
    if (we_cnt !== LAT || en_cnt !== LAT) begin bad++; $display("FAIL store_we got=%0d/%0d exp=%0d", we_cnt, en_cnt, LAT); end
    total++;
    if (first_wdata !== 32'hDEADBEEF || first_addr !== 32'h104 || !stable) begin
      bad++; $display("FAIL store_port got=%h/%h st=%0d exp=deadbeef/104", first_wdata, first_addr, stable);
    end
    total++;
    if (n_dd !== 1 || n_mdr !== 0 || n_ir !== 0) begin bad++; $display("FAIL store_strobes got=%0d%0d%0d exp=100", n_dd, n_mdr, n_ir); end
    total++;
    if (rdata !== exp_rdata) begin bad++; $display("FAIL store_rdata got=%h exp=%h", rdata, exp_rdata); end
  endtask

  task automatic test_simultaneous();
    do_access(1, 1, 0, 0, 32'h200, 32'h300, 0, 32'hA5A5F00D);
    exp_rdata = 32'hA5A5F00D;
    total++;
    if (lat_d !== LAT || lat_if !== 2 * LAT + 2) begin
      bad++; $display("FAIL simul_order got=d%0d/if%0d exp=d%0d/if%0d", lat_d, lat_if, LAT, 2 * LAT + 2);
    end
    total++;
    if (first_addr !== 32'h300) begin bad++; $display("FAIL simul_first got=%h exp=300", first_addr); end
    total++;
    if (n_dd !== 1 || n_ifd !== 1 || n_ir !== 1 || n_mdr !== 1) begin
      bad++; $display("FAIL simul_strobes got=%0d%0d%0d%0d exp=1111", n_dd, n_ifd, n_ir, n_mdr);
    end
  endtask

  task automatic test_latency();
    int l2 = -1, l1 = -1, l15 = -1, c2 = 0, c1 = 0, c15 = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h44; rd_val = 32'h0BADCAFE;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (i == 0) if_req = 0;
      if (if_done) begin c2++; if (l2 < 0) l2 = i; end
      if (x_ifd[0]) begin c1++; if (l1 < 0) l1 = i; end
      if (x_ifd[1]) begin c15++; if (l15 < 0) l15 = i; end
    end
    exp_rdata = 32'h0BADCAFE;
    total++;
    if (l1 !== 1 || c1 !== 1) begin bad++; $display("FAIL lat1 got=%0d n=%0d exp=1 n=1", l1, c1); end
    total++;
    if (l15 !== 15 || c15 !== 1) begin bad++; $display("FAIL lat15 got=%0d n=%0d exp=15 n=1", l15, c15); end
    total++;
    if (l2 !== LAT || c2 !== 1) begin bad++; $display("FAIL lat2_drop got=%0d n=%0d exp=%0d n=1", l2, c2, LAT); end
    total++;
    if (x_rd[1] !== 32'h0BADCAFE || rdata !== exp_rdata) begin
      bad++; $display("FAIL lat_rdata got=%h/%h exp=%h", x_rd[1], rdata, exp_rdata);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      int kind = $urandom_range(0, 4);
      bit fi = kind == 0 || kind >= 3, di = kind >= 1, we = kind == 2 || kind == 4;
      bit early = kind < 3 && $urandom_range(0, 1) == 1;
      logic [31:0] fa = $urandom, da = $urandom, wd = $urandom, rv = $urandom;
      int e_lat_d = di ? LAT : -1, e_lat_if = fi ? (di ? 2 * LAT + 2 : LAT) : -1;
      do_access(fi, di, we, early, fa, da, wd, rv);
      if (fi || !we) exp_rdata = rv;
      total++;
      if (lat_d !== e_lat_d || lat_if !== e_lat_if) begin
        bad++; $display("FAIL rnd%0d_lat got=d%0d/if%0d exp=d%0d/if%0d", k, lat_d, lat_if, e_lat_d, e_lat_if);
      end
      total++;
      if (n_ifd !== int'(fi) || n_dd !== int'(di) || n_ir !== int'(fi) || n_mdr !== int'(di && !we)) begin
        bad++; $display("FAIL rnd%0d_strobes got=%0d%0d%0d%0d exp=%0d%0d%0d%0d", k, n_ifd, n_dd, n_ir, n_mdr,
                        fi, di, fi, di && !we);
      end
      total++;
      if (first_addr !== (di ? da : fa) || !stable || en_cnt !== LAT * (int'(fi) + int'(di)) || we_cnt !== (we ? LAT : 0)) begin
        bad++; $display("FAIL rnd%0d_port got=%h st=%0d en=%0d we=%0d exp=%h", k, first_addr, stable, en_cnt, we_cnt, di ? da : fa);
      end
      if (di && we) begin
        total++;
        if (first_wdata !== wd) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", k, first_wdata, wd); end
      end
      total++;
      if (rdata !== exp_rdata) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", k, rdata, exp_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_simultaneous();
    test_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
